// File: rtl/so_pkg.sv
// Shared types and helpers for the 3x3 median filter pipeline.
// Stage bundles carry data, coordinates and valid together.
package so_pkg;

    typedef logic [7:0] pixel_t;
    typedef logic [5:0] coord_t;

    localparam int IMG_DIM_DEF = 64;

    typedef struct packed {
        logic         valid;
        logic         border;
        pixel_t       centre;
        coord_t       row;
        coord_t       col;
        pixel_t [2:0] lo;
        pixel_t [2:0] mid;
        pixel_t [2:0] hi;
    } s1_t;

    typedef struct packed {
        logic   valid;
        logic   border;
        pixel_t centre;
        coord_t row;
        coord_t col;
        pixel_t maxlo;
        pixel_t midmid;
        pixel_t minhi;
    } s2_t;

    // Clamp c into [min(a,b), max(a,b)] which yields the middle value.
    function automatic pixel_t median3(input pixel_t a,
                                       input pixel_t b,
                                       input pixel_t c);
        pixel_t lo;
        pixel_t hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)
            return lo;
        else if (c > hi)
            return hi;
        else
            return c;
    endfunction

endpackage

// File: rtl/so_median_stage_sort3.sv
// Combinational three-input sorter used for each window row.
// Produces ascending lo/mid/hi from unsigned 8-bit inputs.
module sort3
    import so_pkg::*;
(
    input  pixel_t a,
    input  pixel_t b,
    input  pixel_t c,
    output pixel_t lo,
    output pixel_t mid,
    output pixel_t hi
);

    pixel_t ab_lo;
    pixel_t ab_hi;

    always_comb begin
        ab_lo = (a < b) ? a : b;
        ab_hi = (a < b) ? b : a;
        lo    = (c < ab_lo) ? c : ab_lo;
        hi    = (c > ab_hi) ? c : ab_hi;
        mid   = median3(a, b, c);
    end

endmodule

// File: rtl/so_median_stage.sv
// Median-sort stage: three register stages from a 3x3 window
// to its median, with row/col/valid carried in lockstep.
module so_median_stage
    import so_pkg::*;
#(
    parameter int IMG_DIM     = IMG_DIM_DEF,
    parameter int BORDER_PASS = 1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Stall,
    input  logic       FE_MemWrite,
    input  logic [5:0] FE_row,
    input  logic [5:0] FE_col,
    input  logic [7:0] P0,
    input  logic [7:0] P1,
    input  logic [7:0] P2,
    input  logic [7:0] P3,
    input  logic [7:0] P4,
    input  logic [7:0] P5,
    input  logic [7:0] P6,
    input  logic [7:0] P7,
    input  logic [7:0] P8,
    output logic       SO_MemWrite,
    output logic [5:0] SO_row,
    output logic [5:0] SO_col,
    output logic [7:0] SO_DOUT
);

    localparam coord_t LAST = coord_t'(IMG_DIM - 1);

    pixel_t lo0, lo1, lo2;
    pixel_t mid0, mid1, mid2;
    pixel_t hi0, hi1, hi2;

    s1_t    s1_d, s1_q;
    s2_t    s2_d, s2_q;
    pixel_t dout_d;

    sort3 u_row0 (.a(P0), .b(P1), .c(P2),
                  .lo(lo0), .mid(mid0), .hi(hi0));
    sort3 u_row1 (.a(P3), .b(P4), .c(P5),
                  .lo(lo1), .mid(mid1), .hi(hi1));
    sort3 u_row2 (.a(P6), .b(P7), .c(P8),
                  .lo(lo2), .mid(mid2), .hi(hi2));

    always_comb begin
        s1_d        = '0;
        s1_d.valid  = FE_MemWrite;
        s1_d.border = (FE_row == '0) || (FE_row == LAST) ||
                      (FE_col == '0) || (FE_col == LAST);
        s1_d.centre = P4;
        s1_d.row    = FE_row;
        s1_d.col    = FE_col;
        s1_d.lo     = {lo2, lo1, lo0};
        s1_d.mid    = {mid2, mid1, mid0};
        s1_d.hi     = {hi2, hi1, hi0};
    end

    // Median of 9 = median(max of row lows, median of row mids, min of row highs).
    always_comb begin
        s2_d        = '0;
        s2_d.valid  = s1_q.valid;
        s2_d.border = s1_q.border;
        s2_d.centre = s1_q.centre;
        s2_d.row    = s1_q.row;
        s2_d.col    = s1_q.col;
        s2_d.maxlo  = s1_q.lo[0];
        if (s1_q.lo[1] > s2_d.maxlo)
            s2_d.maxlo = s1_q.lo[1];
        if (s1_q.lo[2] > s2_d.maxlo)
            s2_d.maxlo = s1_q.lo[2];
        s2_d.midmid = median3(s1_q.mid[0], s1_q.mid[1], s1_q.mid[2]);
        s2_d.minhi  = s1_q.hi[0];
        if (s1_q.hi[1] < s2_d.minhi)
            s2_d.minhi = s1_q.hi[1];
        if (s1_q.hi[2] < s2_d.minhi)
            s2_d.minhi = s1_q.hi[2];
    end

    always_comb begin
        dout_d = median3(s2_q.maxlo, s2_q.midmid, s2_q.minhi);
        if ((BORDER_PASS != 0) && s2_q.border)
            dout_d = s2_q.centre;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s1_q        <= '0;
            s2_q        <= '0;
            SO_MemWrite <= 1'b0;
            SO_row      <= '0;
            SO_col      <= '0;
            SO_DOUT     <= '0;
        end else if (!Stall) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            SO_MemWrite <= s2_q.valid;
            SO_row      <= s2_q.row;
            SO_col      <= s2_q.col;
            SO_DOUT     <= dout_d;
        end
    end

endmodule

// File: tb/tb_so_median_stage.sv
// Bench for so_median_stage: two instances (border pass on/off)
// checked against a sort-based median model every cycle.
module tb_so_median_stage;
    import so_pkg::*;

    typedef struct {
        bit v;
        int row;
        int col;
        int med_bp;
        int med_nb;
    } ent_t;

    logic       Clock;
    logic       Resetn;
    logic       Stall;
    logic       FE_MemWrite;
    logic [5:0] FE_row;
    logic [5:0] FE_col;
    logic [7:0] P [9];

    logic       bp_we, nb_we;
    logic [5:0] bp_row, bp_col, nb_row, nb_col;
    logic [7:0] bp_dout, nb_dout;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    ent_t pipe[$];
    ent_t e_cur;

    logic [7:0] wa [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    logic [7:0] ws1 [9] = '{50, 50, 50, 50, 255, 50, 50, 50, 50};
    logic [7:0] ws2 [9] = '{0, 0, 255, 0, 0, 0, 255, 0, 0};
    logic [7:0] wb [9] = '{10, 10, 10, 10, 200, 10, 10, 10, 10};
    logic [7:0] wz [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] wr [5][9];

    so_median_stage #(.IMG_DIM(64), .BORDER_PASS(1)) u_bp (
        .Clock(Clock), .Resetn(Resetn), .Stall(Stall),
        .FE_MemWrite(FE_MemWrite), .FE_row(FE_row), .FE_col(FE_col),
        .P0(P[0]), .P1(P[1]), .P2(P[2]), .P3(P[3]), .P4(P[4]),
        .P5(P[5]), .P6(P[6]), .P7(P[7]), .P8(P[8]),
        .SO_MemWrite(bp_we), .SO_row(bp_row), .SO_col(bp_col),
        .SO_DOUT(bp_dout)
    );

    so_median_stage #(.IMG_DIM(64), .BORDER_PASS(0)) u_nb (
        .Clock(Clock), .Resetn(Resetn), .Stall(Stall),
        .FE_MemWrite(FE_MemWrite), .FE_row(FE_row), .FE_col(FE_col),
        .P0(P[0]), .P1(P[1]), .P2(P[2]), .P3(P[3]), .P4(P[4]),
        .P5(P[5]), .P6(P[6]), .P7(P[7]), .P8(P[8]),
        .SO_MemWrite(nb_we), .SO_row(nb_row), .SO_col(nb_col),
        .SO_DOUT(nb_dout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int ref_med9(input logic [7:0] w [9]);
        int a [9];
        int t;
        for (int i = 0; i < 9; i++) a[i] = int'(w[i]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    function automatic ent_t mk_ent();
        ent_t e;
        logic [7:0] w [9];
        bit b;
        for (int i = 0; i < 9; i++) w[i] = P[i];
        b = (FE_row == 0) || (FE_row == 63) || (FE_col == 0) || (FE_col == 63);
        e.v = FE_MemWrite;
        e.row = int'(FE_row);
        e.col = int'(FE_col);
        e.med_nb = ref_med9(w);
        e.med_bp = b ? int'(P[4]) : e.med_nb;
        return e;
    endfunction

    function automatic ent_t zero_ent();
        ent_t e;
        e.v = 0; e.row = 0; e.col = 0; e.med_bp = 0; e.med_nb = 0;
        return e;
    endfunction

    // Model: output is whatever was sampled three un-stalled edges ago.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pipe.delete();
            repeat (3) pipe.push_back(zero_ent());
        end else if (!Stall) begin
            pipe.push_back(mk_ent());
            void'(pipe.pop_front());
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_on && Resetn === 1'b1 && pipe.size() == 3) begin
            e_cur = pipe[0];
            chk("bp_we", 32'(bp_we), 32'(e_cur.v));
            chk("nb_we", 32'(nb_we), 32'(e_cur.v));
            if (e_cur.v) begin
                chk("bp_row", 32'(bp_row), e_cur.row);
                chk("bp_col", 32'(bp_col), e_cur.col);
                chk("bp_dout", 32'(bp_dout), e_cur.med_bp);
                chk("nb_row", 32'(nb_row), e_cur.row);
                chk("nb_col", 32'(nb_col), e_cur.col);
                chk("nb_dout", 32'(nb_dout), e_cur.med_nb);
            end
        end
    end

    task automatic drive(input bit v, input int r, input int c,
                         input logic [7:0] w [9]);
        FE_MemWrite = v;
        FE_row = 6'(r);
        FE_col = 6'(c);
        for (int i = 0; i < 9; i++) P[i] = w[i];
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic rand_win(output logic [7:0] w [9]);
        bit narrow;
        narrow = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < 9; i++)
            w[i] = narrow ? 8'($urandom_range(0, 3) * 80) : 8'($urandom_range(0, 255));
    endtask

    task automatic run_lit(input string nm, input int r, input int c,
                           input logic [7:0] w [9], input int exp_bp,
                           input int exp_nb);
        chk({nm, "_model"}, ref_med9(w), exp_nb);
        drive(1, r, c, w);
        tick();
        drive(0, 20, 20, wz);
        tick();
        chk({nm, "_early"}, 32'(bp_we), 0);
        tick();
        chk({nm, "_we"}, 32'(bp_we), 1);
        chk({nm, "_row"}, 32'(bp_row), r);
        chk({nm, "_col"}, 32'(bp_col), c);
        chk({nm, "_bp"}, 32'(bp_dout), exp_bp);
        chk({nm, "_nb"}, 32'(nb_dout), exp_nb);
    endtask

    initial begin
        logic [7:0] w [9];
        int cnt;
        int sv [5] = '{1, 0, 1, 0, 1};
        int wexp [8] = '{0, 0, 1, 0, 1, 0, 1, 0};

        Resetn = 1'b0;
        Stall = 1'b0;
        drive(0, 0, 0, wz);
        tick();
        tick();
        chk("rst_we", 32'(bp_we), 0);
        chk("rst_row", 32'(bp_row), 0);
        chk("rst_col", 32'(bp_col), 0);
        chk("rst_dout", 32'(bp_dout), 0);
        Resetn = 1'b1;
        chk_on = 1;
        tick();

        run_lit("basic", 10, 10, wa, 5, 5);
        run_lit("salt", 20, 30, ws1, 50, 50);
        run_lit("salt2", 20, 30, ws2, 0, 0);
        run_lit("brow0", 0, 5, wb, 200, 10);
        run_lit("brow63", 63, 5, wb, 200, 10);
        run_lit("bcol63", 5, 63, wb, 200, 10);
        run_lit("bcol0", 5, 0, wb, 200, 10);

        for (int i = 0; i < 5; i++) rand_win(wr[i]);
        for (int k = 0; k < 8; k++) begin
            if (k < 5) drive(sv[k] == 1, 10 + k, 20 + k, wr[k]);
            else drive(0, 1, 1, wz);
            tick();
            chk("stream_we", 32'(bp_we), wexp[k]);
        end

        for (int i = 0; i < 4; i++) rand_win(wr[i]);
        for (int k = 0; k < 3; k++) begin
            drive(1, 30 + k, 31, wr[k]);
            tick();
        end
        drive(1, 33, 31, wr[3]);
        Stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_we", 32'(bp_we), 1);
            chk("stall_row", 32'(bp_row), 30);
            chk("stall_dout", 32'(nb_dout), ref_med9(wr[0]));
        end
        Stall = 1'b0;
        tick();
        drive(0, 1, 1, wz);
        for (int k = 1; k < 4; k++) begin
            chk("resume_row", 32'(bp_row), 30 + k);
            chk("resume_dout", 32'(nb_dout), ref_med9(wr[k]));
            chk("resume_we", 32'(bp_we), 1);
            tick();
        end
        chk("resume_end", 32'(bp_we), 0);

        for (int k = 0; k < 3; k++) begin
            rand_win(w);
            drive(1, 40 + k, 41, w);
            tick();
        end
        chk("prerst_we", 32'(bp_we), 1);
        #1 Resetn = 1'b0;
        #1;
        chk("arst_we", 32'(bp_we), 0);
        chk("arst_row", 32'(bp_row), 0);
        chk("arst_col", 32'(bp_col), 0);
        chk("arst_dout", 32'(bp_dout), 0);
        drive(0, 1, 1, wz);
        tick();
        Resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bp_we === 1'b1 || nb_we === 1'b1) cnt++;
        end
        chk("no_stale", cnt, 0);

        for (int k = 0; k < 400; k++) begin
            Stall = ($urandom_range(0, 4) == 0);
            if (!Stall) begin
                rand_win(w);
                drive($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 5) == 0) ? 63 * $urandom_range(0, 1) : $urandom_range(0, 63),
                      ($urandom_range(0, 5) == 0) ? 63 * $urandom_range(0, 1) : $urandom_range(0, 63),
                      w);
            end
            tick();
        end
        Stall = 1'b0;
        drive(0, 1, 1, wz);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
